// File: rtl/clk_gen_checker.sv
// clk_gen_checker: measures half-periods of a received divided test clock,
// checks them against the expected speed setting, reports lock and counts errors.
module clk_gen_checker #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TOL         = 1,
  parameter int LOCK_CNT    = 16,
  parameter int TIMEOUT     = 255,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  input  logic [3:0]       exp_ctr,
  input  logic             err_clr,
  output logic             locked,
  output logic             no_signal,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_interval,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t r_state, w_state_nx;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_s_d1;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0] r_exp;
  logic [MW-1:0] r_match_cnt, w_match_nx;
  logic [ERR_W-1:0] w_err_nx;
  logic [CNT_W:0] w_exp_iv, w_cnt_x;
  logic w_s, w_edge, w_active, w_exp_chg, w_tmo, w_meas, w_match, w_err_inc;
  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_edge    = w_s ^ r_s_d1;
  assign w_active  = r_state != IDLE;
  assign w_exp_chg = w_active && (exp_ctr != r_exp);
  assign w_tmo     = w_active && !w_edge && !w_exp_chg && (r_cnt == CNT_W'(TIMEOUT));
  assign w_meas    = w_active && w_edge && !w_exp_chg;
  // Tolerance window evaluated one bit wider so neither side can wrap
  assign w_exp_iv  = (CNT_W+1)'(exp_ctr) + (CNT_W+1)'(1);
  assign w_cnt_x   = {1'b0, r_cnt};
  assign w_match   = (w_cnt_x + (CNT_W+1)'(TOL) >= w_exp_iv) && (w_cnt_x <= w_exp_iv + (CNT_W+1)'(TOL));
  assign w_err_inc = (r_state == LOCKED) && ((w_meas && !w_match) || w_tmo);
  assign w_err_nx  = err_clr ? '0 : (w_err_inc && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
  assign locked    = r_state == LOCKED;
  assign no_signal = r_state == IDLE;
  always_comb begin
    w_state_nx = r_state;
    w_match_nx = r_match_cnt;
    if (w_exp_chg) begin
      w_state_nx = ACQUIRE;
      w_match_nx = '0;
    end else if (w_tmo) begin
      w_state_nx = IDLE;
      w_match_nx = '0;
    end else if (r_state == IDLE && w_edge) begin
      w_state_nx = ACQUIRE;
      w_match_nx = '0;
    end else if (w_meas && !w_match) begin
      w_state_nx = ACQUIRE;
      w_match_nx = '0;
    end else if (w_meas && r_state == ACQUIRE) begin
      w_match_nx = r_match_cnt + MW'(1);
      w_state_nx = (w_match_nx == MW'(LOCK_CNT)) ? LOCKED : ACQUIRE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sync        <= '0;
      r_s_d1        <= 1'b0;
      r_cnt         <= '0;
      r_exp         <= '0;
      r_match_cnt   <= '0;
      err_cnt       <= '0;
      meas_valid    <= 1'b0;
      meas_interval <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_sync      <= {r_sync[SYNC_STAGES-2:0], signal_in};
      r_s_d1      <= w_s;
      r_cnt       <= w_edge ? CNT_W'(1) : (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
      r_exp       <= exp_ctr;
      r_match_cnt <= w_match_nx;
      err_cnt     <= w_err_nx;
      meas_valid  <= w_meas;
      if (w_meas) meas_interval <= r_cnt;
    end
  end
endmodule

// File: tb/tb_clk_gen_checker.sv
// tb_clk_gen_checker: directed stimulus with a queue-based scoreboard checked on meas_valid.
module tb_clk_gen_checker;
  logic clk = 1'b0, rst = 1'b1, signal_in = 1'b0, err_clr = 1'b0;
  logic [3:0] exp_ctr = 4'd3;
  logic locked, no_signal, meas_valid;
  logic [7:0] meas_interval;
  logic [15:0] err_cnt;
  int errors = 0, checks = 0;
  typedef struct {int iv; bit lk; int err;} exp_t;
  exp_t q[$];
  exp_t m_e;

  always #5 clk = ~clk;

  clk_gen_checker dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .exp_ctr(exp_ctr), .err_clr(err_clr),
    .locked(locked), .no_signal(no_signal), .meas_valid(meas_valid),
    .meas_interval(meas_interval), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe: unexpected meas_valid, interval %0d at %0t", meas_interval, $time);
      end else begin
        m_e = q.pop_front();
        chk("interval", meas_interval, m_e.iv);
        chk("strobe_locked", locked, m_e.lk);
        chk("strobe_err_cnt", err_cnt, m_e.err);
      end
    end
  end

  task automatic tog(input int iv, input bit lk, input int err);
    signal_in = ~signal_in;
    q.push_back('{iv, lk, err});
  endtask

  task automatic step(input int n, input bit lk, input int err);
    repeat (n) @(posedge clk);
    #1 tog(n, lk, err);
  endtask

  task automatic first_edge();
    @(posedge clk);
    #1 signal_in = ~signal_in;
  endtask

  task automatic lock_run(input int n, input int err);
    for (int i = 1; i <= 16; i++) step(n, i == 16, err);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_no_signal"}, no_signal, 1);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_meas_interval"}, meas_interval, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst = 1'b0;
    // lock at exp_ctr=3 with 4-cycle half-periods
    first_edge();
    lock_run(4, 0);
    // inside tolerance, then outside tolerance, then relock
    step(5, 1, 0);
    step(7, 0, 1);
    lock_run(4, 1);
    // expected setting changes while locked
    repeat (3) @(posedge clk);
    #1 exp_ctr = 4'd7;
    @(posedge clk);
    #1 chk("expchg_locked", locked, 0);
    chk("expchg_err_cnt", err_cnt, 1);
    chk("expchg_no_signal", no_signal, 0);
    tog(4, 0, 1);
    for (int i = 0; i < 18; i++) step(4, 0, 1);
    lock_run(8, 1);
    // loss of signal
    repeat (200) @(posedge clk);
    #1 chk("hold_locked", locked, 1);
    chk("hold_no_signal", no_signal, 0);
    repeat (100) @(posedge clk);
    #1 chk("tmo_no_signal", no_signal, 1);
    chk("tmo_locked", locked, 0);
    chk("tmo_err_cnt", err_cnt, 2);
    first_edge();
    lock_run(8, 2);
    // fastest setting
    repeat (3) @(posedge clk);
    #1 exp_ctr = 4'd0;
    @(posedge clk);
    #1 tog(4, 0, 2);
    lock_run(1, 2);
    // slowest setting
    repeat (3) @(posedge clk);
    #1 exp_ctr = 4'd15;
    @(posedge clk);
    #1 tog(4, 0, 2);
    lock_run(16, 2);
    // err_clr coincides with an error increment
    repeat (18) @(posedge clk);
    #1 tog(18, 0, 0);
    repeat (2) @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    repeat (16) @(posedge clk);
    #1 tog(19, 0, 0);
    lock_run(16, 0);
    drain();
    // asynchronous reset mid-lock
    repeat (3) @(posedge clk);
    #3 chk("pre_rst_locked", locked, 1);
    rst = 1'b1;
    #1 chk_reset("async_rst");
    signal_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    first_edge();
    lock_run(16, 0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end
endmodule
